// File: rtl/clk_div_multi.sv
// Multi-channel programmable divider: per channel a 50% clock and a 1-cycle tick.
// Divisor reloads are shadowed and take effect at the next wrap or while disabled.
module clk_div_multi #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 26,
   parameter int DEF_DIV = 25000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sync_clr,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH-1:0]       div_load,
   input  logic [NUM_CH*CNT_W-1:0] div_val,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       pending
);

   localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] active;
      logic [CNT_W-1:0] shadow;
      logic [CNT_W-1:0] raw;
      logic [CNT_W-1:0] ld_val;
      logic             co;
      logic             tk;
      logic             pend;
      logic             term;

      assign raw    = div_val[i*CNT_W +: CNT_W];
      // a zero divisor would underflow active-1, so it runs as N=1
      assign ld_val = (raw == '0) ? ONE : raw;
      assign term   = en[i] && (cnt == active - ONE);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt    <= '0;
            active <= DEF;
            shadow <= DEF;
            pend   <= 1'b0;
            co     <= 1'b0;
            tk     <= 1'b0;
         end else if (sync_clr) begin
            cnt <= '0;
            co  <= 1'b0;
            tk  <= 1'b0;
         end else if (!en[i]) begin
            cnt <= '0;
            co  <= 1'b0;
            tk  <= 1'b0;
            if (div_load[i]) begin
               shadow <= ld_val;
               pend   <= 1'b1;
            end else if (pend) begin
               active <= shadow;
               pend   <= 1'b0;
            end
         end else if (term) begin
            cnt <= '0;
            co  <= ~co;
            tk  <= 1'b1;
            if (div_load[i]) begin
               active <= ld_val;
               shadow <= ld_val;
               pend   <= 1'b0;
            end else if (pend) begin
               active <= shadow;
               pend   <= 1'b0;
            end
         end else begin
            cnt <= cnt + ONE;
            tk  <= 1'b0;
            if (div_load[i]) begin
               shadow <= ld_val;
               pend   <= 1'b1;
            end
         end
      end

      assign clk_out[i] = co;
      assign tick[i]    = tk;
      assign pending[i] = pend;
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: default divisor, reloads, clamp,
// phase alignment and asynchronous reset.
module tb_clk_div_multi;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 26;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    sync_clr;
   logic [NUM_CH-1:0]       en;
   logic [NUM_CH-1:0]       div_load;
   logic [NUM_CH*CNT_W-1:0] div_val;
   logic [NUM_CH-1:0]       clk_out;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH-1:0]       pending;

   int vectors     = 0;
   int miscompares = 0;

   clk_div_multi #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W),
      .DEF_DIV(25000)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sync_clr(sync_clr),
      .en      (en),
      .div_load(div_load),
      .div_val (div_val),
      .clk_out (clk_out),
      .tick    (tick),
      .pending (pending)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_val(input int ch, input int v);
      div_val[ch*CNT_W +: CNT_W] = CNT_W'(v);
   endtask

   // load while disabled: pending one cycle, applied the next
   task automatic idle_load(input int ch, input int v);
      set_val(ch, v);
      div_load[ch] = 1'b1;
      step(1);
      div_load = '0;
      step(1);
   endtask

   initial begin
      rst      = 1'b1;
      sync_clr = 1'b0;
      en       = '0;
      div_load = '0;
      div_val  = '0;
      step(2);
      chk("rst clk_out", 32'(clk_out), 32'h0);
      chk("rst tick", 32'(tick), 32'h0);
      chk("rst pending", 32'(pending), 32'h0);
      rst = 1'b0;

      // default divisor 25000 on ch0
      en = 4'b0001;
      step(24999);
      chk("def tick@24999", 32'(tick[0]), 32'h0);
      chk("def clk@24999", 32'(clk_out[0]), 32'h0);
      step(1);
      chk("def tick@25000", 32'(tick[0]), 32'h1);
      chk("def clk@25000", 32'(clk_out[0]), 32'h1);
      step(1);
      chk("def tick@25001", 32'(tick[0]), 32'h0);
      step(24998);
      chk("def clk@49999", 32'(clk_out[0]), 32'h1);
      chk("def tick@49999", 32'(tick[0]), 32'h0);
      step(1);
      chk("def tick@50000", 32'(tick[0]), 32'h1);
      chk("def clk@50000", 32'(clk_out[0]), 32'h0);
      en = '0;
      step(1);
      chk("dis outs", 32'({clk_out, tick}), 32'h0);

      // ch1 N=3 loaded while disabled
      set_val(1, 3);
      div_load[1] = 1'b1;
      step(1);
      chk("n3 pend set", 32'(pending[1]), 32'h1);
      div_load = '0;
      step(1);
      chk("n3 pend clr", 32'(pending[1]), 32'h0);
      en[1] = 1'b1;
      step(2);
      chk("n3 tick@2", 32'(tick[1]), 32'h0);
      step(1);
      chk("n3 tick@3", 32'(tick[1]), 32'h1);
      chk("n3 clk@3", 32'(clk_out[1]), 32'h1);
      step(1);
      chk("n3 tick@4", 32'(tick[1]), 32'h0);
      chk("n3 clk@4", 32'(clk_out[1]), 32'h1);
      step(2);
      chk("n3 tick@6", 32'(tick[1]), 32'h1);
      chk("n3 clk@6", 32'(clk_out[1]), 32'h0);
      step(3);
      chk("n3 clk@9", 32'({clk_out[1], tick[1]}), 32'h3);
      en = '0;
      step(1);

      // ch2 N=10, reload 4 at cnt=2, then reload 2 on a wrap
      idle_load(2, 10);
      en[2] = 1'b1;
      step(2);
      set_val(2, 4);
      div_load[2] = 1'b1;
      step(1);
      div_load = '0;
      chk("rt pend@3", 32'(pending[2]), 32'h1);
      step(6);
      chk("rt pend@9", 32'(pending[2]), 32'h1);
      chk("rt tick@9", 32'(tick[2]), 32'h0);
      step(1);
      chk("rt tick@10", 32'(tick[2]), 32'h1);
      chk("rt pend@10", 32'(pending[2]), 32'h0);
      chk("rt clk@10", 32'(clk_out[2]), 32'h1);
      step(3);
      chk("rt tick@13", 32'(tick[2]), 32'h0);
      step(1);
      chk("rt tick@14", 32'(tick[2]), 32'h1);
      chk("rt clk@14", 32'(clk_out[2]), 32'h0);
      step(3);
      set_val(2, 2);
      div_load[2] = 1'b1;
      step(1);
      div_load = '0;
      chk("co tick@18", 32'(tick[2]), 32'h1);
      chk("co pend@18", 32'(pending[2]), 32'h0);
      step(1);
      chk("co tick@19", 32'(tick[2]), 32'h0);
      step(1);
      chk("co tick@20", 32'(tick[2]), 32'h1);
      chk("co pend@20", 32'(pending[2]), 32'h0);
      en = '0;
      step(1);

      // ch3 zero divisor clamps to 1
      idle_load(3, 0);
      en[3] = 1'b1;
      step(1);
      chk("z tick/clk@1", 32'({tick[3], clk_out[3]}), 32'h3);
      step(1);
      chk("z tick/clk@2", 32'({tick[3], clk_out[3]}), 32'h2);
      step(1);
      chk("z tick/clk@3", 32'({tick[3], clk_out[3]}), 32'h3);
      en = '0;
      step(1);

      // sync_clr on ch0 N=5 and ch1 N=7
      set_val(0, 5);
      set_val(1, 7);
      div_load = 4'b0011;
      step(1);
      div_load = '0;
      step(1);
      en = 4'b0011;
      step(8);
      chk("sc clk pre", 32'(clk_out[1:0]), 32'h3);
      sync_clr = 1'b1;
      step(1);
      sync_clr = 1'b0;
      chk("sc clk post", 32'(clk_out[1:0]), 32'h0);
      chk("sc tick post", 32'(tick[1:0]), 32'h0);
      step(4);
      chk("sc tick@4", 32'(tick[1:0]), 32'h0);
      step(1);
      chk("sc tick@5", 32'(tick[1:0]), 32'h1);
      step(2);
      chk("sc tick@7", 32'(tick[1:0]), 32'h2);
      chk("sc clk@7", 32'(clk_out[1:0]), 32'h3);

      // asynchronous reset with a pending load on ch0
      set_val(0, 9);
      div_load[0] = 1'b1;
      step(1);
      div_load = '0;
      chk("ar pend", 32'(pending[0]), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar outs", 32'({clk_out, tick, pending}), 32'h0);
      #1;
      rst = 1'b0;
      en  = 4'b0001;
      step(24999);
      chk("ar tick@24999", 32'(tick[0]), 32'h0);
      chk("ar pend@24999", 32'(pending[0]), 32'h0);
      step(1);
      chk("ar tick@25000", 32'(tick[0]), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
